struct_array_unpacker: RTL

//  Receive-side counterpart of the packed-struct array transform stage.

---
 rtl/struct_array_unpacker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/struct_array_unpacker.sv
// Receive-side unpacker: captures a whole packet array, undoes the forward transform, streams entries one per beat.
// Optional build macro STRUCT_ARRAY_UNPACK_PARITY_EN adds a registered pkt_parity output.
package struct_array_unpacker_pkg;
   typedef struct packed {
      logic [7:0] data;
      logic [3:0] tag;
   } packet_t;
endpackage

module struct_array_unpacker
   import struct_array_unpacker_pkg::*;
#(
   parameter int unsigned NUM_PKTS = 4,
   parameter logic [7:0]  DATA_INC = 8'd1,
   parameter logic [3:0]  TAG_MASK = 4'b1010
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        arr_valid,
   output logic                        arr_ready,
   input  packet_t                     packets_in [NUM_PKTS],
   output logic                        pkt_valid,
   input  logic                        pkt_ready,
   output packet_t                     pkt_out,
   output logic [$clog2(NUM_PKTS)-1:0] pkt_idx,
   output logic                        pkt_last,
`ifdef STRUCT_ARRAY_UNPACK_PARITY_EN
   output logic                        pkt_parity,
`endif
   output logic                        busy
);
   localparam int unsigned IW = $clog2(NUM_PKTS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PKTS - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

   function automatic packet_t restore(input packet_t p);
      packet_t r;
      r.data = p.data - DATA_INC;
      r.tag  = p.tag ^ TAG_MASK;
      return r;
   endfunction

   function automatic logic parity_of(input packet_t p);
      return ^{p.data, p.tag};
   endfunction

   state_t          state_r, state_nxt_s;
   logic [IW-1:0]   idx_r, idx_nxt_s;
   packet_t         buf_r [NUM_PKTS];
   packet_t         buf_nxt_s [NUM_PKTS];
   logic            pkt_valid_r, valid_nxt_s;
   packet_t         pkt_out_r, out_nxt_s;
   logic            pkt_last_r, last_nxt_s;
   logic            load_s;
   logic [IW-1:0]   idx_inc_s;

   // arr_ready is combinational from pkt_ready so a new array can replace the last beat without a bubble
   assign arr_ready = (state_r == IDLE) || ((state_r == SEND) && pkt_last_r && pkt_ready);
   assign pkt_valid = pkt_valid_r;
   assign pkt_out   = pkt_out_r;
   assign pkt_idx   = idx_r;
   assign pkt_last  = pkt_last_r;
   assign busy      = (state_r == SEND);
   assign idx_inc_s = idx_r + {{(IW-1){1'b0}}, 1'b1};

   // Next-state decode: capture, advance or drain
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      buf_nxt_s   = buf_r;
      valid_nxt_s = pkt_valid_r;
      out_nxt_s   = pkt_out_r;
      last_nxt_s  = pkt_last_r;
      load_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (arr_valid) begin
               load_s = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         SEND: begin
            if (pkt_ready) begin
               if (idx_r != LAST_IDX) begin
                  idx_nxt_s  = idx_inc_s;
                  out_nxt_s  = restore(buf_r[idx_inc_s]);
                  last_nxt_s = (idx_inc_s == LAST_IDX);
               end else if (arr_valid) begin
                  load_s = 1'b1;
               end else begin
                  state_nxt_s = IDLE;
                  idx_nxt_s   = {IW{1'b0}};
                  valid_nxt_s = 1'b0;
                  out_nxt_s   = packet_t'(12'h000);
                  last_nxt_s  = 1'b0;
               end
            end else begin
               state_nxt_s = SEND;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            idx_nxt_s   = {IW{1'b0}};
            valid_nxt_s = 1'b0;
            out_nxt_s   = packet_t'(12'h000);
            last_nxt_s  = 1'b0;
         end
      endcase
      if (load_s) begin
         buf_nxt_s   = packets_in;
         state_nxt_s = SEND;
         idx_nxt_s   = {IW{1'b0}};
         valid_nxt_s = 1'b1;
         out_nxt_s   = restore(packets_in[0]);
         last_nxt_s  = 1'b0;
      end else begin
         load_s = 1'b0;
      end
   end

   // State, buffer and registered stream outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         idx_r       <= {IW{1'b0}};
         pkt_valid_r <= 1'b0;
         pkt_out_r   <= packet_t'(12'h000);
         pkt_last_r  <= 1'b0;
         for (int i = 0; i < NUM_PKTS; i++) begin
            buf_r[i] <= packet_t'(12'h000);
         end
      end else begin
         state_r     <= state_nxt_s;
         idx_r       <= idx_nxt_s;
         pkt_valid_r <= valid_nxt_s;
         pkt_out_r   <= out_nxt_s;
         pkt_last_r  <= last_nxt_s;
         buf_r       <= buf_nxt_s;
      end
   end

`ifdef STRUCT_ARRAY_UNPACK_PARITY_EN
   logic pkt_parity_r;
   assign pkt_parity = pkt_parity_r;

   // Parity tracks the packet register it covers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_parity_r <= 1'b0;
      end else begin
         pkt_parity_r <= parity_of(out_nxt_s);
      end
   end
`endif

endmodule
